// File: rtl/spi_dump_master.sv
// spi_dump_master
// Debug-side initiator for SPI memory/latch inspection. On i_start it sends one
// request word per address (base, base+1, ...), followed by one flush word,
// through the SPI master's start/done handshake. The reply to request k arrives
// during transfer k+1, so each reply is tagged with the address of the previous
// request and presented on a single-entry valid/ready stream.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_start, i_base_addr, i_count,
//   i_sel                           burst command (sampled only when idle)
//   o_spi_tx, o_spi_start           request word and one-cycle transfer start
//   i_spi_done, i_spi_rx            transfer finished pulse and received word
//   o_data, o_data_addr,
//   o_data_valid, i_data_ready      reply stream toward the debug host
//   o_busy, o_done                  activity flag and burst-complete pulse
module spi_dump_master #(
  parameter int unsigned NB_BITS = 32,
  parameter int unsigned NB_ADDR = 16,
  parameter int unsigned NB_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [NB_ADDR-1:0] i_base_addr,
  input  logic [NB_CNT-1:0]  i_count,
  input  logic [1:0]         i_sel,
  output logic [NB_BITS-1:0] o_spi_tx,
  output logic               o_spi_start,
  input  logic               i_spi_done,
  input  logic [NB_BITS-1:0] i_spi_rx,
  output logic [NB_BITS-1:0] o_data,
  output logic [NB_ADDR-1:0] o_data_addr,
  output logic               o_data_valid,
  input  logic               i_data_ready,
  output logic               o_busy,
  output logic               o_done
);

  // Transfer index needs one extra bit: it runs 0..count inclusive.
  localparam int unsigned NB_K = NB_CNT + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_PUSH,
    ST_FINISH
  } state_t;

  state_t             state;
  logic [NB_K-1:0]    k;
  logic [NB_ADDR-1:0] base_q;
  logic [NB_CNT-1:0]  cnt_q;
  logic [1:0]         sel_q;

  // Word for transfer kk: request for base+kk while kk<count, flush word after.
  function automatic logic [NB_BITS-1:0] req_word(
    input logic [NB_K-1:0]    kk,
    input logic [NB_CNT-1:0]  cnt,
    input logic [NB_ADDR-1:0] base,
    input logic [1:0]         sel
  );
    logic [NB_BITS-1:0] w;
    w = '0;
    if (kk < {1'b0, cnt}) begin
      w[NB_ADDR-1:0]       = base + NB_ADDR'(kk);
      w[NB_ADDR+1:NB_ADDR] = sel;
    end
    return w;
  endfunction

  // Burst sequencer; every output is a register updated on state transitions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      k            <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      sel_q        <= '0;
      o_spi_tx     <= '0;
      o_spi_start  <= 1'b0;
      o_data       <= '0;
      o_data_addr  <= '0;
      o_data_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            base_q <= i_base_addr;
            cnt_q  <= i_count;
            sel_q  <= i_sel;
            k      <= '0;
            o_busy <= 1'b1;
            if (i_count == '0) begin
              state  <= ST_FINISH;
              o_done <= 1'b1;
            end else begin
              state       <= ST_SEND;
              o_spi_start <= 1'b1;
              o_spi_tx    <= req_word('0, i_count, i_base_addr, i_sel);
            end
          end
        end

        ST_SEND: begin
          o_spi_start <= 1'b0;
          state       <= ST_WAIT;
        end

        ST_WAIT: begin
          if (i_spi_done) begin
            o_data <= i_spi_rx;
            if (k == '0) begin
              // First reply carries nothing requested by this burst: drop it.
              k           <= NB_K'(1);
              state       <= ST_SEND;
              o_spi_start <= 1'b1;
              o_spi_tx    <= req_word(NB_K'(1), cnt_q, base_q, sel_q);
            end else begin
              state        <= ST_PUSH;
              o_data_valid <= 1'b1;
              o_data_addr  <= base_q + NB_ADDR'(k) - NB_ADDR'(1);
            end
          end
        end

        ST_PUSH: begin
          // Reply buffer is single-entry: the next transfer waits for the handshake.
          if (i_data_ready) begin
            o_data_valid <= 1'b0;
            if (k == {1'b0, cnt_q}) begin
              state  <= ST_FINISH;
              o_done <= 1'b1;
            end else begin
              k           <= k + NB_K'(1);
              state       <= ST_SEND;
              o_spi_start <= 1'b1;
              o_spi_tx    <= req_word(k + NB_K'(1), cnt_q, base_q, sel_q);
            end
          end
        end

        ST_FINISH: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dump_master.sv
// Directed bench for spi_dump_master: an SPI responder with programmable latency,
// a reply-stream monitor with optional backpressure, and one task per scenario.
module tb_spi_dump_master;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [15:0] i_base_addr;
  logic [15:0] i_count;
  logic [1:0]  i_sel;
  logic [31:0] o_spi_tx;
  logic        o_spi_start;
  logic        i_spi_done;
  logic [31:0] i_spi_rx;
  logic [31:0] o_data;
  logic [15:0] o_data_addr;
  logic        o_data_valid;
  logic        i_data_ready;
  logic        o_busy;
  logic        o_done;

  int total;
  int bad;

  logic [31:0] tx_log [16];
  logic [31:0] rx_tab [16];
  logic [31:0] out_d  [16];
  logic [15:0] out_a  [16];
  int n_start, n_rx, n_out, n_donep;
  int tx_unstable, hold_unstable, overlap, min_low;
  int lat;
  bit bp_mode;

  spi_dump_master dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_count      (i_count),
    .i_sel        (i_sel),
    .o_spi_tx     (o_spi_tx),
    .o_spi_start  (o_spi_start),
    .i_spi_done   (i_spi_done),
    .i_spi_rx     (i_spi_rx),
    .o_data       (o_data),
    .o_data_addr  (o_data_addr),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI responder: logs each started word, answers after 'lat' idle cycles.
  initial begin : spi_resp
    bit pend;
    int cd;
    pend = 1'b0;
    cd   = 0;
    forever begin
      @(negedge clk);
      i_spi_done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (o_spi_start) begin
        if (n_start < 16) tx_log[n_start] = o_spi_tx;
        n_start++;
        pend = 1'b1;
        cd   = lat;
      end else if (pend) begin
        if (n_start >= 1 && n_start <= 16 && o_spi_tx !== tx_log[n_start-1]) tx_unstable++;
        if (cd == 0) begin
          i_spi_done = 1'b1;
          i_spi_rx   = (n_rx < 16) ? rx_tab[n_rx] : 32'h0;
          n_rx++;
          pend = 1'b0;
        end else begin
          cd--;
        end
      end
    end
  end

  // Reply stream monitor; in backpressure mode ready stays low 5 cycles per word.
  initial begin : out_mon
    int wc;
    bit held;
    logic [31:0] hold_d;
    logic [15:0] hold_a;
    wc = 0;
    held = 1'b0;
    hold_d = '0;
    hold_a = '0;
    forever begin
      @(negedge clk);
      if (bp_mode) begin
        if (o_data_valid && wc < 5) begin
          i_data_ready = 1'b0;
          wc++;
        end else if (o_data_valid) begin
          i_data_ready = 1'b1;
        end else begin
          i_data_ready = 1'b0;
          wc = 0;
        end
      end else begin
        i_data_ready = 1'b1;
      end
      if (o_done) n_donep++;
      if (o_data_valid && held && (o_data !== hold_d || o_data_addr !== hold_a)) hold_unstable++;
      held   = o_data_valid && !i_data_ready;
      hold_d = o_data;
      hold_a = o_data_addr;
      if (o_data_valid && i_data_ready) begin
        if (n_out < 16) begin
          out_d[n_out] = o_data;
          out_a[n_out] = o_data_addr;
        end
        n_out++;
        if (bp_mode && wc < min_low) min_low = wc;
      end
      if (o_spi_start && o_data_valid) overlap++;
    end
  end

  task automatic clear_logs();
    n_start = 0; n_rx = 0; n_out = 0; n_donep = 0;
    tx_unstable = 0; hold_unstable = 0; overlap = 0; min_low = 99;
  endtask

  // Pulses i_start for one cycle, then scrambles the command inputs.
  task automatic launch(input logic [15:0] b, input logic [15:0] c, input logic [1:0] s);
    @(negedge clk);
    i_base_addr = b;
    i_count     = c;
    i_sel       = s;
    i_start     = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
    i_base_addr = 16'hBEEF;
    i_count     = 16'h0009;
    i_sel       = 2'b10;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (n_donep > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_spi_tx, o_spi_start, o_data, o_data_addr, o_data_valid, o_busy, o_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got tx=%h st=%b d=%h a=%h v=%b busy=%b done=%b, want all 0",
               o_spi_tx, o_spi_start, o_data, o_data_addr, o_data_valid, o_busy, o_done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_busy: got %b want 0", o_busy);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_tx [4];
    bit ok;
    exp_tx[0] = 32'h0000_0010; exp_tx[1] = 32'h0000_0011;
    exp_tx[2] = 32'h0000_0012; exp_tx[3] = 32'h0000_0000;
    clear_logs();
    lat = 0;
    for (int i = 0; i < 16; i++) rx_tab[i] = 32'hA0 + i;
    launch(16'h0010, 16'd3, 2'b00);
    total++;
    if (o_spi_start !== 1'b1 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL start_latency: got start=%b busy=%b want 1 1", o_spi_start, o_busy);
    end
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: got no o_done want o_done"); end
    total++;
    if (n_start !== 4) begin bad++; $display("FAIL basic_starts: got %0d want 4", n_start); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tx_log[i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL basic_tx%0d: got %h want %h", i, tx_log[i], exp_tx[i]);
      end
    end
    total++;
    if (n_out !== 3) begin bad++; $display("FAIL basic_nout: got %0d want 3", n_out); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_a[i] !== 16'h0010 + 16'(i) || out_d[i] !== 32'hA1 + i) begin
        bad++;
        $display("FAIL basic_out%0d: got (%h,%h) want (%h,%h)", i, out_a[i], out_d[i],
                 16'h0010 + 16'(i), 32'hA1 + i);
      end
    end
    total++;
    if (n_donep !== 1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: got pulses=%0d busy=%b want 1 0", n_donep, o_busy);
    end
    total++;
    if (tx_unstable !== 0) begin bad++; $display("FAIL basic_tx_hold: got %0d changes want 0", tx_unstable); end
  endtask

  task automatic test_count_zero();
    clear_logs();
    @(negedge clk);
    i_base_addr = 16'h1234; i_count = 16'd0; i_sel = 2'b00; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    total++;
    if (o_done !== 1'b1 || o_busy !== 1'b1 || o_spi_start !== 1'b0) begin
      bad++;
      $display("FAIL zero_first: got done=%b busy=%b start=%b want 1 1 0", o_done, o_busy, o_spi_start);
    end
    @(negedge clk);
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_second: got done=%b busy=%b want 0 0", o_done, o_busy);
    end
    repeat (4) @(negedge clk);
    total++;
    if (n_start !== 0 || n_donep !== 1) begin
      bad++;
      $display("FAIL zero_counts: got starts=%0d dones=%0d want 0 1", n_start, n_donep);
    end
  endtask

  task automatic test_sel_rd();
    bit ok;
    clear_logs();
    lat = 2;
    rx_tab[0] = 32'h1111_1111;
    rx_tab[1] = 32'hDEAD_BEEF;
    launch(16'h0000, 16'd1, 2'b11);
    wait_done(ok);
    total++;
    if (!ok || n_start !== 2) begin
      bad++;
      $display("FAIL sel_starts: got done=%b starts=%0d want 1 2", ok, n_start);
    end
    total++;
    if (tx_log[0] !== 32'h0003_0000 || tx_log[1] !== 32'h0000_0000) begin
      bad++;
      $display("FAIL sel_tx: got %h %h want 00030000 00000000", tx_log[0], tx_log[1]);
    end
    total++;
    if (n_out !== 1 || out_a[0] !== 16'h0000 || out_d[0] !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL sel_out: got n=%0d (%h,%h) want 1 (0000,deadbeef)", n_out, out_a[0], out_d[0]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    lat = 1;
    bp_mode = 1'b1;
    for (int i = 0; i < 16; i++) rx_tab[i] = 32'h5500_0000 + i;
    launch(16'h0200, 16'd2, 2'b01);
    wait_done(ok);
    bp_mode = 1'b0;
    total++;
    if (!ok || n_start !== 3 || n_out !== 2) begin
      bad++;
      $display("FAIL bp_counts: got done=%b starts=%0d outs=%0d want 1 3 2", ok, n_start, n_out);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (out_a[i] !== 16'h0200 + 16'(i) || out_d[i] !== 32'h5500_0001 + i) begin
        bad++;
        $display("FAIL bp_out%0d: got (%h,%h) want (%h,%h)", i, out_a[i], out_d[i],
                 16'h0200 + 16'(i), 32'h5500_0001 + i);
      end
    end
    total++;
    if (hold_unstable !== 0 || overlap !== 0 || min_low < 5) begin
      bad++;
      $display("FAIL bp_hold: got changes=%0d overlap=%0d low=%0d want 0 0 >=5",
               hold_unstable, overlap, min_low);
    end
    total++;
    if (tx_log[1] !== 32'h0001_0201 || tx_log[2] !== 32'h0) begin
      bad++;
      $display("FAIL bp_tx: got %h %h want 00010201 00000000", tx_log[1], tx_log[2]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_tx [4];
    logic [15:0] exp_a  [3];
    bit ok;
    exp_tx[0] = 32'h0002_FFFE; exp_tx[1] = 32'h0002_FFFF;
    exp_tx[2] = 32'h0002_0000; exp_tx[3] = 32'h0000_0000;
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000;
    clear_logs();
    lat = 0;
    for (int i = 0; i < 16; i++) rx_tab[i] = 32'hC0DE_0000 + i;
    launch(16'hFFFE, 16'd3, 2'b10);
    wait_done(ok);
    total++;
    if (!ok || n_out !== 3) begin bad++; $display("FAIL wrap_counts: got done=%b outs=%0d want 1 3", ok, n_out); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tx_log[i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL wrap_tx%0d: got %h want %h", i, tx_log[i], exp_tx[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_a[i] !== exp_a[i] || out_d[i] !== 32'hC0DE_0001 + i) begin
        bad++;
        $display("FAIL wrap_out%0d: got (%h,%h) want (%h,%h)", i, out_a[i], out_d[i],
                 exp_a[i], 32'hC0DE_0001 + i);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    bit seen;
    clear_logs();
    lat = 8;
    for (int i = 0; i < 16; i++) rx_tab[i] = 32'h7700_0000 + i;
    launch(16'h0040, 16'd3, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n_start >= 2) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL mid_second_start: got %0d starts want 2", n_start); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_spi_tx, o_spi_start, o_data, o_data_addr, o_data_valid, o_busy, o_done} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got tx=%h st=%b d=%h a=%h v=%b busy=%b done=%b, want all 0",
               o_spi_tx, o_spi_start, o_data, o_data_addr, o_data_valid, o_busy, o_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (n_donep !== 0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_done: got dones=%0d busy=%b want 0 0", n_donep, o_busy);
    end

    // Clean burst afterward, with a stray i_start while it runs.
    clear_logs();
    lat = 1;
    for (int i = 0; i < 16; i++) rx_tab[i] = 32'hB0 + i;
    launch(16'h0100, 16'd2, 2'b01);
    repeat (3) @(negedge clk);
    i_base_addr = 16'h0999; i_count = 16'd7; i_sel = 2'b11; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(ok);
    total++;
    if (!ok || n_start !== 3 || n_out !== 2 || n_donep !== 1) begin
      bad++;
      $display("FAIL after_counts: got done=%b starts=%0d outs=%0d dones=%0d want 1 3 2 1",
               ok, n_start, n_out, n_donep);
    end
    total++;
    if (tx_log[0] !== 32'h0001_0100 || tx_log[2] !== 32'h0) begin
      bad++;
      $display("FAIL after_tx: got %h %h want 00010100 00000000", tx_log[0], tx_log[2]);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (out_a[i] !== 16'h0100 + 16'(i) || out_d[i] !== 32'hB1 + i) begin
        bad++;
        $display("FAIL after_out%0d: got (%h,%h) want (%h,%h)", i, out_a[i], out_d[i],
                 16'h0100 + 16'(i), 32'hB1 + i);
      end
    end
    repeat (5) @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || n_start !== 3) begin
      bad++;
      $display("FAIL after_idle: got busy=%b starts=%0d want 0 3", o_busy, n_start);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_base_addr = '0;
    i_count = '0;
    i_sel = '0;
    i_spi_done = 1'b0;
    i_spi_rx = '0;
    i_data_ready = 1'b1;
    bp_mode = 1'b0;
    lat = 0;
    for (int i = 0; i < 16; i++) begin
      tx_log[i] = '0; rx_tab[i] = '0; out_d[i] = '0; out_a[i] = '0;
    end
    clear_logs();
    test_reset();
    test_basic();
    test_count_zero();
    test_sel_rd();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
